// File: rtl/mem_dump_reader.sv
// mem_dump_reader: bus initiator that reads a contiguous RAM range over the
// synchronous 6502-side memory bus and streams the bytes out on a
// valid/ready byte stream. The bus is used only while the arbiter grants it.
// Optional checksum beat: define MEM_DUMP_CHECKSUM_EN to append the 8-bit sum
// of all dumped bytes as one extra beat. That beat then carries o_tlast.
module mem_dump_reader #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_first,
    input  logic [ADDR_W-1:0] i_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bus_req,
    input  logic              i_bus_gnt,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rw,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_tdata,
    output logic              o_tvalid,
    input  logic              i_tready,
    output logic              o_tlast
);

    // The capture cycle is hard-wired one cycle after the address cycle.
    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("mem_dump_reader: only RD_LAT == 1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        CAPT,
        SEND,
        DONE,
        CSUM
    } state_t;

    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q;      // address of the byte currently being fetched/sent
    logic [ADDR_W:0]   rem_q;      // beats still to hand over, 1..2^ADDR_W
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] cur_inc;
    logic              accept;
    logic              beat_hs;
    logic              last_beat;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign span      = i_last - i_first;
    assign cur_inc   = cur_q + ADDR_ONE;
    assign accept    = (state_q == IDLE) && i_start;
    assign beat_hs   = (state_q == SEND) && i_tready;
    assign last_beat = (rem_q == REM_ONE);

    // Outputs that are pure functions of the registered state.
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_bus_req = (state_q == REQ) || (state_q == ADDR) ||
                       (state_q == CAPT) || (state_q == SEND);
    assign o_rw      = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
    assign o_tvalid  = (state_q == SEND) || (state_q == CSUM);
`else
    assign o_tvalid  = (state_q == SEND);
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a lost grant always falls back to REQ for a re-read.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = REQ;
            REQ:  if (i_bus_gnt) state_d = ADDR;
            ADDR: state_d = i_bus_gnt ? CAPT : REQ;
            CAPT: state_d = i_bus_gnt ? SEND : REQ;
            SEND: begin
                if (i_tready) begin
                    if (last_beat) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = i_bus_gnt ? ADDR : REQ;
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: if (i_tready) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: range pointer, beat counter, bus address and stream byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cur_q   <= '0;
            rem_q   <= '0;
            o_addr  <= '0;
            o_tdata <= '0;
            o_tlast <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            if (accept) begin
                cur_q <= i_first;
                rem_q <= {1'b0, span} + REM_ONE;
`ifdef MEM_DUMP_CHECKSUM_EN
                csum_q <= '0;
`endif
            end
            if (beat_hs) begin
                cur_q <= cur_inc;
                rem_q <= rem_q - REM_ONE;
`ifdef MEM_DUMP_CHECKSUM_EN
                csum_q <= csum_q + o_tdata;
`endif
            end
            // Load the address on entry to ADDR so it is on the bus that cycle.
            if (state_d == ADDR) o_addr <= beat_hs ? cur_inc : cur_q;
            // Data is only trusted if the grant held through the capture cycle.
            if ((state_q == CAPT) && i_bus_gnt) begin
                o_tdata <= i_data;
`ifdef MEM_DUMP_CHECKSUM_EN
                o_tlast <= 1'b0;
`else
                o_tlast <= last_beat;
`endif
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            if (beat_hs && last_beat) begin
                o_tdata <= csum_q + o_tdata;
                o_tlast <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: RAM model with one-cycle read
// latency, scoreboard queue of expected beats, stream stability monitor.
module tb_mem_dump_reader;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_first;
    logic [15:0] i_last;
    logic        o_busy;
    logic        o_done;
    logic        o_bus_req;
    logic        i_bus_gnt;
    logic [15:0] o_addr;
    logic        o_rw;
    logic [7:0]  i_data;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_tlast;

    logic [7:0]  mem [0:65535];
    logic [8:0]  exp_q [$];     // {tlast, tdata}

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          beats   = 0;
    int          done_cnt = 0;
    int          last_hs = 0;
    int          hs_gap  = 0;
    logic        bp      = 1'b0;
    logic        chk_range = 1'b0;
    logic [15:0] rng_lo  = '0;
    logic [15:0] rng_hi  = '0;

    mem_dump_reader #(.ADDR_W(16), .RD_LAT(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (i_start),
        .i_first   (i_first),
        .i_last    (i_last),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_bus_req (o_bus_req),
        .i_bus_gnt (i_bus_gnt),
        .o_addr    (o_addr),
        .o_rw      (o_rw),
        .i_data    (i_data),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .i_tready  (i_tready),
        .o_tlast   (o_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: data for the address presented this cycle arrives next cycle.
    always @(posedge clk) i_data <= mem[o_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_range(input logic [15:0] f, input logic [15:0] l);
        logic [15:0] span;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  sum;
        span = l - f;
        sum  = '0;
        for (int k = 0; k <= int'(span); k++) begin
            a   = f + 16'(k);
            b   = mem[a];
            sum = sum + b;
`ifdef MEM_DUMP_CHECKSUM_EN
            exp_q.push_back({1'b0, b});
`else
            exp_q.push_back({(k == int'(span)), b});
`endif
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back({1'b1, sum});
`endif
    endtask

    task automatic start_dump(input logic [15:0] f, input logic [15:0] l);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_first = f;
        i_last  = l;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t;
        t = 0;
        while (t < budget) begin
            @(negedge clk);
            t++;
            if (o_done) break;
        end
        check({tag, "_done_seen"}, 32'(o_done), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(o_busy),    32'd0);
        check({tag, "_done"},  32'(o_done),    32'd0);
        check({tag, "_req"},   32'(o_bus_req), 32'd0);
        check({tag, "_addr"},  32'(o_addr),    32'd0);
        check({tag, "_rw"},    32'(o_rw),      32'd1);
        check({tag, "_tdata"}, 32'(o_tdata),   32'd0);
        check({tag, "_tvalid"},32'(o_tvalid),  32'd0);
        check({tag, "_tlast"}, 32'(o_tlast),   32'd0);
    endtask

    // Stream ready: held high, or random ~30% duty in backpressure mode.
    initial begin
        i_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on handshake, hold stability, address range.
    initial begin
        logic        hold_v;
        logic [7:0]  hold_d;
        logic        hold_l;
        logic [15:0] prev_addr;
        logic [15:0] offs;
        logic [8:0]  e;
        hold_v    = 1'b0;
        hold_d    = '0;
        hold_l    = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v    = 1'b0;
                prev_addr = o_addr;
            end else begin
                if (hold_v) begin
                    check("hold_tvalid", 32'(o_tvalid), 32'd1);
                    check("hold_tdata",  32'(o_tdata),  32'(hold_d));
                    check("hold_tlast",  32'(o_tlast),  32'(hold_l));
                end
                if (o_tvalid && i_tready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_tdata", 32'(o_tdata), 32'(e[7:0]));
                        check("beat_tlast", 32'(o_tlast), 32'(e[8]));
                    end
                    check("beat_rw", 32'(o_rw), 32'd1);
                    beats++;
                    hs_gap  = cyc - last_hs;
                    last_hs = cyc;
                end
                if (o_done) done_cnt++;
                if (chk_range && (o_addr != prev_addr)) begin
                    offs = o_addr - rng_lo;
                    check("addr_range", 32'(offs <= (rng_hi - rng_lo)), 32'd1);
                end
                hold_v    = o_tvalid && !i_tready;
                hold_d    = o_tdata;
                hold_l    = o_tlast;
                prev_addr = o_addr;
            end
        end
    end

    initial begin
        int lat;
        int d0;
        int b0;
        int t;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_first   = '0;
        i_last    = '0;
        i_bus_gnt = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h22;
        mem[16'h0202] = 8'h33; mem[16'h0203] = 8'h44;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hA2;
        mem[16'h0000] = 8'hA3; mem[16'h0001] = 8'hA4;
        mem[16'h0700] = 8'hFF; mem[16'h0701] = 8'h02;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 4-byte dump with latency, throughput, range and single done pulse.
        rng_lo    = 16'h0200;
        rng_hi    = 16'h0203;
        chk_range = 1'b1;
        d0        = done_cnt;
        push_range(16'h0200, 16'h0203);
        start_dump(16'h0200, 16'h0203);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_tvalid) break;
        end
        check("first_latency", 32'(lat), 32'd4);
        check("busy_during", 32'(o_busy), 32'd1);
        wait_done("basic", 200);
        check("beat_gap", 32'(hs_gap), 32'd3);
        chk_range = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("done_count", 32'(done_cnt - d0), 32'd1);

        // Address wrap through 0xFFFF, then a single-beat range.
        push_range(16'hFFFE, 16'h0001);
        start_dump(16'hFFFE, 16'h0001);
        wait_done("wrap", 200);
        push_range(16'h1234, 16'h1234);
        start_dump(16'h1234, 16'h1234);
        wait_done("single", 100);

        // Random backpressure over a 16-byte range.
        bp = 1'b1;
        push_range(16'h0400, 16'h040F);
        start_dump(16'h0400, 16'h040F);
        wait_done("bp", 3000);
        bp = 1'b0;

        // Grant drop for 3 cycles starting at the capture of 0x0302.
        push_range(16'h0300, 16'h0305);
        start_dump(16'h0300, 16'h0305);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (o_addr == 16'h0302) break;
        end
        check("gnt_addr_seen", 32'(o_addr), 32'h0302);
        @(posedge clk);
        #1;
        i_bus_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("gnt_req_hold", 32'(o_bus_req), 32'd1);
        end
        @(posedge clk);
        #1;
        i_bus_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("gnt_readdr", 32'(o_addr), 32'h0302);
        check("gnt_readdr_req", 32'(o_bus_req), 32'd1);
        wait_done("gnt", 200);

        // Reset after beat 2 of 8, then a clean rerun with a spurious start.
        push_range(16'h0500, 16'h0507);
        b0 = beats;
        start_dump(16'h0500, 16'h0507);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            #1;
            t++;
            if (beats - b0 >= 2) break;
        end
        check("midrst_beats", 32'(beats - b0), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_range(16'h0500, 16'h0507);
        start_dump(16'h0500, 16'h0507);
        repeat (2) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_first = 16'h0600;
        i_last  = 16'h0601;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("rerun", 200);
        repeat (4) @(negedge clk);
        check("rerun_stays_idle", 32'(o_busy), 32'd0);

        // Two bytes FF, 02 (checksum 0x01 when enabled).
        push_range(16'h0700, 16'h0701);
        start_dump(16'h0700, 16'h0701);
        wait_done("sum", 100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
